spi_slave_regs: RTL and testbench

- SPI responder (slave) holding an 8 x 8-bit register file; the counterpart to the master side of the Master_Slave system.
- Accepts 2-byte frames from an SPI master in any of the four modes: command/address byte, then data byte (read or write).
- Oversamples SCLK, SS_n and MOSI on the system clock; drives MISO. The host side can preload registers and observe all of them.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_slave_regs.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder register block.
package spi_pkg;

  // SPI mode encodings, {CPOL,CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Bit positions of CPOL/CPHA inside the mode word.
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  // Command byte: bit 7 set means read, clear means write.
  localparam int CMD_RW_BIT = 7;

  // A frame is a command byte followed by a data byte.
  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall
// detection on the synchronized value. STAGES must be 2 or more.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  // Next values: shift the raw input in, remember the last synchronized value.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_i};
    prev_d  = chain_q[STAGES-1];
  end

  // Synchronizer chain and edge-history flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI responder with an NREGS x DATA_W register file. Frames are a command
// byte (read/write flag + address) followed by a data byte, in any SPI mode.
// The host side can preload any register with a one-cycle ld_en strobe and
// sees the whole file on regs_flat.
//
// Host interface: ld_en is a single-cycle strobe with no back-pressure; the
// register named by ld_addr takes ld_data on the clock edge where ld_en is
// high. If an SPI write commits to the same register on that edge, the SPI
// data is kept.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int NREGS       = 8,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    ss_n,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [DATA_W-1:0]       ld_data,
  output logic [NREGS*DATA_W-1:0] regs_flat,
  output logic                    wr_strobe,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic                    frame_done,
  output state_e                  dbg_state
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  // Synchronized SPI inputs.
  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_fall, ss_rise_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_i(sclk),
    .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .async_i(ss_n),
    .sync_o(ss_s), .rise_o(ss_rise_unused), .fall_o(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_i(mosi),
    .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  // Frame state.
  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [DATA_W-2:0]             shin_q, shin_d;
  logic [DATA_W-1:0]             shout_q, shout_d;
  logic                          rw_q, rw_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic                          cpol_q, cpol_d;
  logic                          cpha_q, cpha_d;
  logic                          miso_q, miso_d;
  logic                          oe_q, oe_d;
  logic                          wr_pend_q, wr_pend_d;
  logic                          wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]             wr_addr_q, wr_addr_d;
  logic                          done_q, done_d;
  logic [NREGS-1:0][DATA_W-1:0]  regs_q, regs_d;

  logic              leading, trailing, sample_edge, shift_edge;
  logic [DATA_W-1:0] byte_in;
  logic              spi_we;

  // Edge roles follow the mode latched at ss_n fall.
  always_comb begin
    leading     = cpol_q ? sclk_fall : sclk_rise;
    trailing    = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trailing : leading;
    shift_edge  = cpha_q ? leading : trailing;
    byte_in     = {shin_q, mosi_s};
  end

  // Frame FSM, shift registers, output strobes and register-file update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    miso_d      = miso_q;
    wr_pend_d   = 1'b0;
    done_d      = 1'b0;
    spi_we      = 1'b0;
    // The strobe trails the register commit by one cycle.
    wr_strobe_d = wr_pend_q;
    wr_addr_d   = wr_pend_q ? addr_q : wr_addr_q;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          cpol_d  = mode[CPOL_BIT];
          cpha_d  = mode[CPHA_BIT];
        end
      end
      CMD: begin
        miso_d = 1'b0;
        if (ss_s) begin
          state_d = IDLE;
        end else if (sample_edge) begin
          shin_d = byte_in[DATA_W-2:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            rw_d    = byte_in[CMD_RW_BIT];
            addr_d  = byte_in[ADDR_W-1:0];
            // Snapshot for reads; later host preloads do not disturb it.
            shout_d = regs_q[byte_in[ADDR_W-1:0]];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (ss_s) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else begin
          if (shift_edge && rw_q) begin
            miso_d  = shout_q[DATA_W-1];
            shout_d = {shout_q[DATA_W-2:0], 1'b0};
          end
          if (sample_edge) begin
            shin_d = byte_in[DATA_W-2:0];
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              done_d  = 1'b1;
              state_d = DONE;
              if (!rw_q) begin
                spi_we    = 1'b1;
                wr_pend_d = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        if (ss_s) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase

    oe_d = (state_d != IDLE) && !ss_s;

    regs_d = regs_q;
    if (ld_en) begin
      regs_d[ld_addr] = ld_data;
    end
    if (spi_we) begin
      regs_d[addr_q] = byte_in;
    end
  end

  // All state registers; reset clears the register file as well.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      done_q      <= 1'b0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_pend_q   <= wr_pend_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      done_q      <= done_d;
      regs_q      <= regs_d;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = oe_q;
  assign regs_flat  = regs_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Testbench for spi_slave_regs: acts as SPI master and host, and checks
// against an array-based register model.
module tb_spi_slave_regs;
  import spi_pkg::*;

  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int H      = 6;   // clk cycles per SCLK half period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]              mode;
  logic                    ss_n, sclk, mosi;
  logic                    miso, miso_oe;
  logic                    ld_en;
  logic [ADDR_W-1:0]       ld_addr;
  logic [DATA_W-1:0]       ld_data;
  logic [NREGS*DATA_W-1:0] regs_flat;
  logic                    wr_strobe;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    frame_done;
  state_e                  dbg_state;

  spi_slave_regs dut (
    .clk(clk), .reset(reset), .mode(mode), .ss_n(ss_n), .sclk(sclk),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int ws_cnt = 0;
  int fd_cnt = 0;
  logic [DATA_W-1:0] model [NREGS];
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] exp_wr_addr;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) ws_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  function automatic logic [NREGS*DATA_W-1:0] model_flat();
    logic [NREGS*DATA_W-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*DATA_W +: DATA_W] = model[i];
    return f;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Wait one SCLK half period; with arm set, pulse ld_en on the clk edge
  // where the DUT acts on the SCLK edge driven just before this call.
  task automatic half_wait(input bit arm);
    for (int c = 0; c < H; c++) begin
      @(negedge clk);
      ld_en = arm && (c == SYNC - 1);
    end
    ld_en = 1'b0;
  endtask

  task automatic host_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en    = 1'b0;
    model[a] = d;
  endtask

  // One SPI transfer of nbits bits of {cmd,dat}; rx collects MISO on the
  // sample edges of bits 9..16. oe_bad counts sample points with miso_oe low.
  task automatic spi_xfer(input logic [1:0] m, input logic [7:0] cmd,
                          input logic [7:0] dat, input int nbits,
                          input bit collide, input bit keep_sel,
                          output logic [7:0] rx, output int oe_bad);
    logic [15:0] fr;
    bit cpol, cpha, last;
    fr = {cmd, dat};
    cpol = m[1];
    cpha = m[0];
    rx = 8'h00;
    oe_bad = 0;
    mode = m;
    sclk = cpol;
    mosi = cpha ? 1'b0 : fr[15];
    half_wait(0);
    half_wait(0);
    ss_n = 1'b0;
    half_wait(0);
    mode = ~m;  // must be ignored: mode was latched at select
    for (int i = 0; i < nbits; i++) begin
      last = collide && (i == 15);
      if (!cpha) begin
        if (i >= 8) rx = {rx[6:0], miso};
        if (miso_oe !== 1'b1) oe_bad++;
        sclk = ~cpol;
        half_wait(last);
        sclk = cpol;
        mosi = (i < 15) ? fr[14-i] : 1'b0;
        half_wait(0);
      end else begin
        sclk = ~cpol;
        mosi = fr[15-i];
        half_wait(0);
        if (i >= 8) rx = {rx[6:0], miso};
        if (miso_oe !== 1'b1) oe_bad++;
        sclk = cpol;
        half_wait(last);
      end
    end
    if (!keep_sel) begin
      ss_n = 1'b1;
      half_wait(0);
      half_wait(0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = MODE0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    exp_wr_addr = '0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL reset_regs: got %h expected %h", regs_flat, model_flat()); end
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
    n_vec++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    n_vec++; if (wr_addr !== 3'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
  endtask

  task automatic test_mode0_write();
    logic [7:0] rx; int oe_bad, ws0, fd0;
    ws0 = ws_cnt; fd0 = fd_cnt;
    spi_xfer(MODE0, 8'h03, 8'hA5, 16, 0, 0, rx, oe_bad);
    model[3] = 8'hA5; exp_wr_addr = 3'd3;
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL m0_write_regs: got %h expected %h", regs_flat, model_flat()); end
    n_vec++; if (ws_cnt - ws0 != 1) begin n_err++; $display("FAIL m0_write_strobes: got %0d expected 1", ws_cnt - ws0); end
    n_vec++; if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL m0_write_done: got %0d expected 1", fd_cnt - fd0); end
    n_vec++; if (wr_addr !== exp_wr_addr) begin n_err++; $display("FAIL m0_write_addr: got %0d expected %0d", wr_addr, exp_wr_addr); end
    n_vec++; if (rx !== 8'h00) begin n_err++; $display("FAIL m0_write_miso: got %h expected 00", rx); end
    n_vec++; if (oe_bad != 0) begin n_err++; $display("FAIL m0_write_oe: got %0d low samples expected 0", oe_bad); end
  endtask

  task automatic test_mode1_read();
    logic [7:0] rx; int oe_bad, ws0, fd0;
    host_load(3'd2, 8'h51);
    ws0 = ws_cnt; fd0 = fd_cnt;
    spi_xfer(MODE1, 8'h82, 8'($urandom), 16, 0, 0, rx, oe_bad);
    n_vec++; if (rx !== 8'h51) begin n_err++; $display("FAIL m1_read_data: got %h expected 51", rx); end
    n_vec++; if (oe_bad != 0) begin n_err++; $display("FAIL m1_read_oe_sel: got %0d low samples expected 0", oe_bad); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL m1_read_oe_desel: got %b expected 0", miso_oe); end
    n_vec++; if (ws_cnt - ws0 != 0) begin n_err++; $display("FAIL m1_read_strobe: got %0d expected 0", ws_cnt - ws0); end
    n_vec++; if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL m1_read_done: got %0d expected 1", fd_cnt - fd0); end
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL m1_read_regs: got %h expected %h", regs_flat, model_flat()); end
  endtask

  task automatic test_mode23();
    logic [7:0] rx; int oe_bad;
    for (int m = 2; m <= 3; m++) begin
      host_load(3'd7, 8'h6A);
      spi_xfer(2'(m), 8'h87, 8'h00, 16, 0, 0, rx, oe_bad);
      n_vec++; if (rx !== 8'h6A) begin n_err++; $display("FAIL m%0d_read_data: got %h expected 6a", m, rx); end
      spi_xfer(2'(m), 8'h01, 8'hC8, 16, 0, 0, rx, oe_bad);
      model[1] = 8'hC8; exp_wr_addr = 3'd1;
      n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL m%0d_write_regs: got %h expected %h", m, regs_flat, model_flat()); end
      n_vec++; if (wr_addr !== exp_wr_addr) begin n_err++; $display("FAIL m%0d_write_addr: got %0d expected %0d", m, wr_addr, exp_wr_addr); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx; int oe_bad, ws0, fd0;
    ws0 = ws_cnt; fd0 = fd_cnt;
    spi_xfer(MODE0, 8'h04, 8'h3C, 12, 0, 1, rx, oe_bad);
    ss_n = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL abort_oe: got %b expected 0", miso_oe); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL abort_state: got %0d expected IDLE", dbg_state); end
    repeat (2 * H) @(negedge clk);
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL abort_regs: got %h expected %h", regs_flat, model_flat()); end
    n_vec++; if (ws_cnt - ws0 != 0) begin n_err++; $display("FAIL abort_strobe: got %0d expected 0", ws_cnt - ws0); end
    n_vec++; if (fd_cnt - fd0 != 0) begin n_err++; $display("FAIL abort_done: got %0d expected 0", fd_cnt - fd0); end
    spi_xfer(MODE0, 8'h04, 8'h3C, 16, 0, 0, rx, oe_bad);
    model[4] = 8'h3C; exp_wr_addr = 3'd4;
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL post_abort_regs: got %h expected %h", regs_flat, model_flat()); end
    n_vec++; if (ws_cnt - ws0 != 1 || fd_cnt - fd0 != 1) begin n_err++; $display("FAIL post_abort_pulses: got strobe %0d done %0d expected 1 1", ws_cnt - ws0, fd_cnt - fd0); end
  endtask

  task automatic test_collision();
    logic [7:0] rx; int oe_bad;
    ld_addr = 3'd5; ld_data = 8'h11;
    spi_xfer(MODE0, 8'h05, 8'h22, 16, 1, 0, rx, oe_bad);
    model[5] = 8'h22; exp_wr_addr = 3'd5;  // SPI data wins on the same register
    n_vec++; if (regs_flat[5*8 +: 8] !== 8'h22) begin n_err++; $display("FAIL collide_same: got %h expected 22", regs_flat[5*8 +: 8]); end
    ld_addr = 3'd6; ld_data = 8'h11;
    spi_xfer(MODE0, 8'h05, 8'h22, 16, 1, 0, rx, oe_bad);
    model[6] = 8'h11; model[5] = 8'h22;
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL collide_diff: got %h expected %h", regs_flat, model_flat()); end
  endtask

  task automatic test_random();
    logic [7:0] rx, cmd, dat, exp;
    logic [1:0] m;
    logic [ADDR_W-1:0] a;
    bit rd;
    int oe_bad, ws0, fd0, exp_ws;
    ws0 = ws_cnt; fd0 = fd_cnt; exp_ws = 0;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) host_load(3'($urandom), 8'($urandom));
      m   = 2'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      a   = 3'($urandom);
      cmd = {rd, 4'($urandom), a};
      dat = 8'($urandom);
      exp_q.push_back(rd ? model[a] : 8'h00);
      spi_xfer(m, cmd, dat, 16, 0, 0, rx, oe_bad);
      if (!rd) begin model[a] = dat; exp_wr_addr = a; exp_ws++; end
      exp = exp_q.pop_front();
      n_vec++; if (rx !== exp) begin n_err++; $display("FAIL rand_miso[%0d]: mode %0d cmd %h got %h expected %h", k, m, cmd, rx, exp); end
      n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL rand_regs[%0d]: got %h expected %h", k, regs_flat, model_flat()); end
      n_vec++; if (wr_addr !== exp_wr_addr) begin n_err++; $display("FAIL rand_wr_addr[%0d]: got %0d expected %0d", k, wr_addr, exp_wr_addr); end
      n_vec++; if (oe_bad != 0) begin n_err++; $display("FAIL rand_oe[%0d]: got %0d low samples expected 0", k, oe_bad); end
    end
    n_vec++; if (ws_cnt - ws0 != exp_ws) begin n_err++; $display("FAIL rand_strobes: got %0d expected %0d", ws_cnt - ws0, exp_ws); end
    n_vec++; if (fd_cnt - fd0 != 24) begin n_err++; $display("FAIL rand_done: got %0d expected 24", fd_cnt - fd0); end
  endtask

  task automatic test_reset_midread();
    logic [7:0] rx; int oe_bad;
    host_load(3'd0, 8'h9D);
    spi_xfer(MODE0, 8'h80, 8'h00, 12, 0, 1, rx, oe_bad);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL rst_mid_miso: got %b expected 0", miso); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid_oe: got %b expected 0", miso_oe); end
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL rst_mid_regs: got %h expected %h", regs_flat, model_flat()); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_mid_state: got %0d expected IDLE", dbg_state); end
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    spi_xfer(MODE0, 8'h80, 8'h00, 16, 0, 0, rx, oe_bad);
    n_vec++; if (rx !== 8'h00) begin n_err++; $display("FAIL rst_mid_reread: got %h expected 00", rx); end
    n_vec++; if (regs_flat !== model_flat()) begin n_err++; $display("FAIL rst_mid_regs_after: got %h expected %h", regs_flat, model_flat()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mode0_write();
    test_mode1_read();
    test_mode23();
    test_abort();
    test_collision();
    test_random();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
